// File: rtl/rvfi_obi_mem_responder_if.sv
// OBI request/response bundle between a core memory port and its responder.
// master: core side (req/addr/we/be/wdata out); slave: responder (gnt/rvalid/rdata out).
interface rvfi_obi_mem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic [DATA_WIDTH-1:0] addr;
    logic                  we;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/rvfi_obi_mem_responder.sv
// Protocol-legal OBI memory responder: shapes free gnt/rvalid/rdata inputs into legal
// OBI responses (in-order, bounded outstanding, bounded stall) and flags core-side
// request-phase violations.
// Ports: clk_i/rst_ni (async active-low), bus (OBI slave side), rand_* (free candidates),
// rsp_addr_o/rsp_we_o (head txn being answered), outstanding_o, protocol_err_o (sticky).
module rvfi_obi_mem_responder #(
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int MAX_STALL       = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    rvfi_obi_mem_responder_if.slave bus,
    input  logic                  rand_gnt_i,
    input  logic                  rand_rvalid_i,
    input  logic [DATA_WIDTH-1:0] rand_rdata_i,
    output logic [DATA_WIDTH-1:0] rsp_addr_o,
    output logic                  rsp_we_o,
    output logic [2:0]            outstanding_o,
    output logic                  protocol_err_o
);
    localparam int SW = $clog2(MAX_STALL + 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);
    localparam logic [2:0]    OUT_MAX   = 3'(MAX_OUTSTANDING);
    localparam logic [1:0]    LAST      = 2'(MAX_OUTSTANDING - 1);

    logic [2:0]            count;
    logic [SW-1:0]         gstall;
    logic [SW-1:0]         rstall;
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [DATA_WIDTH-1:0] fifo_addr [4];
    logic                  fifo_we   [4];

    // Snapshot of the previous cycle's request, used for hold-stability checking
    logic                  pend;
    logic [DATA_WIDTH-1:0] p_addr;
    logic                  p_we;
    logic [3:0]            p_be;
    logic [DATA_WIDTH-1:0] p_wdata;

    logic full;
    logic busy;
    logic gstall_hit;
    logic rstall_hit;
    logic gnt;
    logic rvalid;
    logic head_we;
    logic hold_err;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == LAST) ? 2'd0 : p + 2'd1;
    endfunction

    assign full       = (count == OUT_MAX);
    assign busy       = (count != 3'd0);
    assign gstall_hit = (gstall == STALL_MAX);
    assign rstall_hit = (rstall == STALL_MAX);

    // count is registered, so a txn can never be answered in its own grant cycle
    assign gnt    = rst_ni & bus.req & ~full & (rand_gnt_i | gstall_hit);
    assign rvalid = rst_ni & busy & (rand_rvalid_i | rstall_hit);

    assign head_we = fifo_we[rd_ptr];

    assign bus.gnt        = gnt;
    assign bus.rvalid     = rvalid;
    assign bus.rdata      = (rvalid & ~head_we) ? rand_rdata_i : '0;
    assign rsp_addr_o     = rvalid ? fifo_addr[rd_ptr] : '0;
    assign rsp_we_o       = rvalid & head_we;
    assign outstanding_o  = count;

    // An ungranted request must be held stable; wdata only matters for writes
    assign hold_err = pend & (~bus.req
                           | (bus.addr != p_addr)
                           | (bus.we != p_we)
                           | (bus.be != p_be)
                           | (bus.we & (bus.wdata != p_wdata)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count          <= '0;
            gstall         <= '0;
            rstall         <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            pend           <= 1'b0;
            p_addr         <= '0;
            p_we           <= 1'b0;
            p_be           <= '0;
            p_wdata        <= '0;
            protocol_err_o <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                fifo_addr[i] <= '0;
                fifo_we[i]   <= 1'b0;
            end
        end else begin
            count <= count + {2'b0, gnt} - {2'b0, rvalid};
            if (gnt) begin
                fifo_addr[wr_ptr] <= bus.addr;
                fifo_we[wr_ptr]   <= bus.we;
                wr_ptr            <= nxt(wr_ptr);
            end
            if (rvalid) begin
                rd_ptr <= nxt(rd_ptr);
            end
            // A full responder is not the core's fault: no grant stall accrues
            if (bus.req & ~gnt & ~full) begin
                gstall <= gstall_hit ? gstall : gstall + SW'(1);
            end else begin
                gstall <= '0;
            end
            if (busy & ~rvalid) begin
                rstall <= rstall_hit ? rstall : rstall + SW'(1);
            end else begin
                rstall <= '0;
            end
            pend    <= bus.req & ~gnt;
            p_addr  <= bus.addr;
            p_we    <= bus.we;
            p_be    <= bus.be;
            p_wdata <= bus.wdata;
            if (hold_err) begin
                protocol_err_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rvfi_obi_mem_responder.sv
// Directed self-checking bench for rvfi_obi_mem_responder (DATA_WIDTH=32,
// MAX_OUTSTANDING=2, MAX_STALL=4); inputs driven 1ns after posedge, outputs checked 1ns later.
module tb_rvfi_obi_mem_responder;
    logic        clk;
    logic        rst_ni;
    logic        rand_gnt;
    logic        rand_rvalid;
    logic [31:0] rand_rdata;
    logic [31:0] rsp_addr;
    logic        rsp_we;
    logic [2:0]  outstanding;
    logic        perr;

    int errors;
    int checks;

    rvfi_obi_mem_responder_if #(.DATA_WIDTH(32)) bus ();

    rvfi_obi_mem_responder #(
        .DATA_WIDTH(32),
        .MAX_OUTSTANDING(2),
        .MAX_STALL(4)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .bus(bus),
        .rand_gnt_i(rand_gnt),
        .rand_rvalid_i(rand_rvalid),
        .rand_rdata_i(rand_rdata),
        .rsp_addr_o(rsp_addr),
        .rsp_we_o(rsp_we),
        .outstanding_o(outstanding),
        .protocol_err_o(perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0b want %0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] a, input logic w);
        bus.req   = r;
        bus.addr  = a;
        bus.we    = w;
        bus.be    = 4'hf;
        bus.wdata = 32'h0000aaaa;
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rst_ni      = 1'b0;
        rand_gnt    = 1'b1;
        rand_rvalid = 1'b1;
        rand_rdata  = 32'hdeadbeef;
        drive(1'b1, 32'h0, 1'b0);

        // In reset: gnt/rvalid forced low despite free inputs high
        tick();
        tick();
        settle();
        chk1("rst_gnt", bus.gnt, 1'b0);
        chk1("rst_rvalid", bus.rvalid, 1'b0);
        chkw("rst_out", {29'b0, outstanding}, 32'd0);
        chk1("rst_perr", perr, 1'b0);
        chkw("rst_rdata", bus.rdata, 32'd0);
        drive(1'b0, 32'h0, 1'b0);
        rst_ni = 1'b1;
        tick();

        // Single read, latency 1
        drive(1'b1, 32'h100, 1'b0);
        settle();
        chk1("rd_gnt", bus.gnt, 1'b1);
        chk1("rd_no_rv_c0", bus.rvalid, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        settle();
        chk1("rd_rvalid", bus.rvalid, 1'b1);
        chkw("rd_addr", rsp_addr, 32'h100);
        chk1("rd_we", rsp_we, 1'b0);
        chkw("rd_rdata", bus.rdata, 32'hdeadbeef);
        chkw("rd_out1", {29'b0, outstanding}, 32'd1);
        tick();
        settle();
        chkw("rd_out0", {29'b0, outstanding}, 32'd0);

        // Grant stall: forced on 5th request cycle; response forced on 5th busy cycle
        rand_gnt    = 1'b0;
        rand_rvalid = 1'b0;
        drive(1'b1, 32'h200, 1'b0);
        for (int k = 0; k < 5; k++) begin
            settle();
            chk1("gstall_gnt", bus.gnt, k == 4);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0);
        for (int j = 0; j < 5; j++) begin
            settle();
            chk1("rstall_rv", bus.rvalid, j == 4);
            if (j == 4) chkw("rstall_addr", rsp_addr, 32'h200);
            tick();
        end
        settle();
        chkw("stall_out0", {29'b0, outstanding}, 32'd0);

        // Three back-to-back reads, full at 2, ordering 0x0,0x4,0x8
        rand_gnt = 1'b1;
        drive(1'b1, 32'h0, 1'b0);
        settle();
        chk1("b2b_gnt0", bus.gnt, 1'b1);
        tick();
        drive(1'b1, 32'h4, 1'b0);
        settle();
        chk1("b2b_gnt1", bus.gnt, 1'b1);
        tick();
        drive(1'b1, 32'h8, 1'b0);
        settle();
        chk1("b2b_full_gnt", bus.gnt, 1'b0);
        chkw("b2b_out2", {29'b0, outstanding}, 32'd2);
        tick();
        for (int j = 0; j < 2; j++) begin
            settle();
            chk1("b2b_wait_rv", bus.rvalid, 1'b0);
            tick();
        end
        settle();
        chk1("b2b_force_rv", bus.rvalid, 1'b1);
        chkw("b2b_head0", rsp_addr, 32'h0);
        chk1("b2b_full_gnt2", bus.gnt, 1'b0);
        tick();
        settle();
        chk1("b2b_gnt2", bus.gnt, 1'b1);
        chk1("b2b_rv_off", bus.rvalid, 1'b0);
        chkw("b2b_out1", {29'b0, outstanding}, 32'd1);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        rand_rvalid = 1'b1;
        settle();
        chk1("b2b_rv1", bus.rvalid, 1'b1);
        chkw("b2b_head1", rsp_addr, 32'h4);
        chkw("b2b_out2b", {29'b0, outstanding}, 32'd2);
        tick();
        settle();
        chkw("b2b_head2", rsp_addr, 32'h8);
        tick();
        settle();
        chkw("b2b_out0", {29'b0, outstanding}, 32'd0);

        // Write then read
        rand_rdata = 32'h12345678;
        drive(1'b1, 32'h300, 1'b1);
        settle();
        chk1("wr_gnt", bus.gnt, 1'b1);
        tick();
        drive(1'b1, 32'h304, 1'b0);
        settle();
        chk1("wr_rd_gnt", bus.gnt, 1'b1);
        chk1("wr_rv", bus.rvalid, 1'b1);
        chk1("wr_we", rsp_we, 1'b1);
        chkw("wr_rdata", bus.rdata, 32'd0);
        chkw("wr_addr", rsp_addr, 32'h300);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        settle();
        chk1("rd2_we", rsp_we, 1'b0);
        chkw("rd2_rdata", bus.rdata, 32'h12345678);
        chkw("rd2_addr", rsp_addr, 32'h304);
        tick();
        settle();
        chk1("no_err_yet", perr, 1'b0);

        // Address change while ungranted -> sticky error
        rand_gnt = 1'b0;
        drive(1'b1, 32'h20, 1'b0);
        tick();
        drive(1'b1, 32'h24, 1'b0);
        settle();
        chk1("perr_pre", perr, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        settle();
        chk1("perr_set", perr, 1'b1);
        tick();
        tick();
        settle();
        chk1("perr_sticky", perr, 1'b1);

        // Reset with two outstanding
        rand_gnt    = 1'b1;
        rand_rvalid = 1'b0;
        drive(1'b1, 32'h40, 1'b0);
        tick();
        drive(1'b1, 32'h44, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        settle();
        chkw("pre_rst_out", {29'b0, outstanding}, 32'd2);
        rand_rvalid = 1'b1;
        rst_ni      = 1'b0;
        settle();
        chkw("mid_rst_out", {29'b0, outstanding}, 32'd0);
        chk1("mid_rst_rv", bus.rvalid, 1'b0);
        chk1("mid_rst_perr", perr, 1'b0);
        tick();
        rst_ni = 1'b1;
        settle();
        chk1("post_rst_rv", bus.rvalid, 1'b0);
        tick();
        settle();
        chk1("post_rst_rv2", bus.rvalid, 1'b0);
        chkw("post_rst_out", {29'b0, outstanding}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
